// File: rtl/controller_sequencer.sv
// SAP-1 control unit: one-hot T1..T6 ring counter plus microinstruction decoder
// producing the W-bus control word for LDA, ADD, SUB, OUT and HLT.
module controller_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic       hlt,
    output logic [5:0] t_state
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_e;

    ring_e state_q, state_d;
    logic  hlt_q, hlt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= T1;
            hlt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hlt_q   <= hlt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hlt_d   = hlt_q;
        if (run && !hlt_q) begin
            // HLT parks the ring at T4 for good; only reset releases it.
            if (state_q == T4 && opcode == OP_HLT) begin
                hlt_d = 1'b1;
            end else begin
                case (state_q)
                    T1:      state_d = T2;
                    T2:      state_d = T3;
                    T3:      state_d = T4;
                    T4:      state_d = T5;
                    T5:      state_d = T6;
                    default: state_d = T1;
                endcase
            end
        end
    end

    always_comb begin
        cp = 1'b0;
        ep = 1'b0;
        lm = 1'b0;
        ce = 1'b0;
        li = 1'b0;
        ei = 1'b0;
        la = 1'b0;
        ea = 1'b0;
        su = 1'b0;
        eu = 1'b0;
        lb = 1'b0;
        lo = 1'b0;
        // Pausing, halting or reset silence every strobe so nothing repeats.
        if (rst_n && run && !hlt_q) begin
            case (state_q)
                T1: begin
                    ep = 1'b1;
                    lm = 1'b1;
                end
                T2: cp = 1'b1;
                T3: begin
                    ce = 1'b1;
                    li = 1'b1;
                end
                T4: begin
                    if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
                        ei = 1'b1;
                        lm = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        ea = 1'b1;
                        lo = 1'b1;
                    end
                end
                T5: begin
                    if (opcode == OP_LDA) begin
                        ce = 1'b1;
                        la = 1'b1;
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        ce = 1'b1;
                        lb = 1'b1;
                    end
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        eu = 1'b1;
                        la = 1'b1;
                        su = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign hlt     = hlt_q;
    assign t_state = state_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Self-checking bench for controller_sequencer: directed instruction scenarios plus
// a randomized run, all compared against a T-step/halt reference model.
module tb_controller_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [3:0] opcode = 4'b0000;
    logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
    logic [5:0] t_state;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: step number 1..6 and the halt flag.
    int   m_t = 1;
    logic m_h = 1'b0;

    localparam logic [11:0] K_CP = 12'h800, K_EP = 12'h400, K_LM = 12'h200, K_CE = 12'h100;
    localparam logic [11:0] K_LI = 12'h080, K_EI = 12'h040, K_LA = 12'h020, K_EA = 12'h010;
    localparam logic [11:0] K_SU = 12'h008, K_EU = 12'h004, K_LB = 12'h002, K_LO = 12'h001;

    wire [11:0] ctrl = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};

    controller_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei), .la(la), .ea(ea),
        .su(su), .eu(eu), .lb(lb), .lo(lo), .hlt(hlt), .t_state(t_state)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] micro_table(input int t, input logic [3:0] op);
        logic [11:0] r;
        r = 12'h000;
        case (t)
            1: r = K_EP | K_LM;
            2: r = K_CP;
            3: r = K_CE | K_LI;
            4: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) r = K_EI | K_LM;
                else if (op == 4'hE) r = K_EA | K_LO;
            end
            5: begin
                if (op == 4'h0) r = K_CE | K_LA;
                else if (op == 4'h1 || op == 4'h2) r = K_CE | K_LB;
            end
            6: begin
                if (op == 4'h1) r = K_EU | K_LA;
                else if (op == 4'h2) r = K_EU | K_SU | K_LA;
            end
            default: r = 12'h000;
        endcase
        return r;
    endfunction

    function automatic logic [11:0] exp_ctrl();
        if (!rst_n || !run || m_h) return 12'h000;
        return micro_table(m_t, opcode);
    endfunction

    function automatic logic [5:0] exp_ts();
        return 6'(1 << (m_t - 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_t = 1;
            m_h = 1'b0;
        end else if (run && !m_h) begin
            if (m_t == 4 && opcode == 4'hF) m_h = 1'b1;
            else m_t = (m_t == 6) ? 1 : m_t + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; opcode = 4'h0;
        tick(); tick();
        n_assert++;
        if (t_state !== 6'b000001) begin
            n_fail++; $display("FAIL reset_t_state got=%b want=000001", t_state);
        end
        n_assert++;
        if (hlt !== 1'b0) begin
            n_fail++; $display("FAIL reset_hlt got=%b want=0", hlt);
        end
        n_assert++;
        if (ctrl !== 12'h000) begin
            n_fail++; $display("FAIL reset_ctrl got=%h want=000", ctrl);
        end
        rst_n = 1'b1; #1;
        n_assert++;
        if (ctrl !== (K_EP | K_LM)) begin
            n_fail++; $display("FAIL reset_release_ctrl got=%h want=%h", ctrl, K_EP | K_LM);
        end
        opcode = 4'h1;
        repeat (4) tick();
        rst_n = 1'b0; #1;
        n_assert++;
        if (ctrl !== 12'h000 || t_state !== 6'b010000) begin
            n_fail++; $display("FAIL midreset_force got ctrl=%h ts=%b want ctrl=000 ts=010000", ctrl, t_state);
        end
        tick();
        rst_n = 1'b1; #1;
        n_assert++;
        if (t_state !== 6'b000001 || ctrl !== (K_EP | K_LM)) begin
            n_fail++; $display("FAIL midreset_abort got ctrl=%h ts=%b want ctrl=%h ts=000001", ctrl, t_state, K_EP | K_LM);
        end
        $display("reset: done, fails so far %0d", n_fail);
    endtask

    task automatic test_instr(input logic [3:0] op);
        opcode = op; run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_assert++;
            if ({t_state, hlt, ctrl} !== {exp_ts(), m_h, exp_ctrl()}) begin
                n_fail++;
                $display("FAIL instr_op%h_T%0d got ts=%b hlt=%b ctrl=%h want ts=%b hlt=%b ctrl=%h",
                         op, i + 1, t_state, hlt, ctrl, exp_ts(), m_h, exp_ctrl());
            end
            tick();
        end
        n_assert++;
        if (t_state !== 6'b000001) begin
            n_fail++; $display("FAIL instr_op%h_wrap got=%b want=000001", op, t_state);
        end
        $display("instr op=%h: 6 steps checked, fails so far %0d", op, n_fail);
    endtask

    task automatic test_hlt();
        opcode = 4'hF; run = 1'b1;
        repeat (3) tick();
        n_assert++;
        if (t_state !== 6'b001000 || ctrl !== 12'h000) begin
            n_fail++; $display("FAIL hlt_T4 got ts=%b ctrl=%h want ts=001000 ctrl=000", t_state, ctrl);
        end
        tick();
        n_assert++;
        if (hlt !== 1'b1 || t_state !== 6'b001000) begin
            n_fail++; $display("FAIL hlt_set got hlt=%b ts=%b want hlt=1 ts=001000", hlt, t_state);
        end
        for (int i = 0; i < 20; i++) begin
            run = 1'($urandom_range(0, 1));
            opcode = 4'($urandom);
            #1;
            n_assert++;
            if (t_state !== 6'b001000 || hlt !== 1'b1 || ctrl !== 12'h000) begin
                n_fail++; $display("FAIL hlt_hold[%0d] got ts=%b hlt=%b ctrl=%h want ts=001000 hlt=1 ctrl=000", i, t_state, hlt, ctrl);
            end
            tick();
        end
        rst_n = 1'b0; run = 1'b1; opcode = 4'h0;
        tick();
        rst_n = 1'b1; #1;
        n_assert++;
        if (hlt !== 1'b0 || t_state !== 6'b000001 || ctrl !== (K_EP | K_LM)) begin
            n_fail++; $display("FAIL hlt_clear got hlt=%b ts=%b ctrl=%h want hlt=0 ts=000001 ctrl=%h", hlt, t_state, ctrl, K_EP | K_LM);
        end
        $display("hlt: done, fails so far %0d", n_fail);
    endtask

    task automatic test_pause();
        int cp_cnt;
        opcode = 4'h1; run = 1'b1;
        tick();
        run = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            n_assert++;
            if (t_state !== 6'b000010 || cp !== 1'b0 || ctrl !== 12'h000) begin
                n_fail++; $display("FAIL pause_hold[%0d] got ts=%b cp=%b ctrl=%h want ts=000010 cp=0 ctrl=000", i, t_state, cp, ctrl);
            end
            tick();
        end
        run = 1'b1; #1;
        cp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cp_cnt += int'(cp);
            n_assert++;
            if ({t_state, ctrl} !== {exp_ts(), exp_ctrl()}) begin
                n_fail++; $display("FAIL pause_resume[%0d] got ts=%b ctrl=%h want ts=%b ctrl=%h", i, t_state, ctrl, exp_ts(), exp_ctrl());
            end
            tick();
        end
        n_assert++;
        if (cp_cnt != 1) begin
            n_fail++; $display("FAIL pause_cp_count got=%0d want=1", cp_cnt);
        end
        $display("pause: done, fails so far %0d", n_fail);
    endtask

    task automatic test_random();
        logic [3:0] ops [5] = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h7};
        int drivers;
        for (int i = 0; i < 400; i++) begin
            if (m_t == 1) begin
                opcode = ops[$urandom_range(0, 4)];
                if ($urandom_range(0, 4) == 0) opcode = 4'($urandom_range(3, 13));
            end
            run   = ($urandom_range(0, 4) != 0);
            rst_n = ($urandom_range(0, 59) != 0);
            #1;
            n_assert++;
            if ({t_state, hlt, ctrl} !== {exp_ts(), m_h, exp_ctrl()}) begin
                n_fail++;
                $display("FAIL rand[%0d] op=%h run=%b rst_n=%b got ts=%b hlt=%b ctrl=%h want ts=%b hlt=%b ctrl=%h",
                         i, opcode, run, rst_n, t_state, hlt, ctrl, exp_ts(), m_h, exp_ctrl());
            end
            drivers = int'(ep) + int'(ce) + int'(ei) + int'(ea) + int'(eu);
            n_assert++;
            if (drivers > 1 || (su && !eu)) begin
                n_fail++; $display("FAIL rand_excl[%0d] got drivers=%0d su=%b eu=%b want drivers<=1 and no su without eu", i, drivers, su, eu);
            end
            tick();
        end
        rst_n = 1'b1;
        $display("random: 400 cycles checked, fails so far %0d", n_fail);
    endtask

    initial begin
        test_reset();
        test_instr(4'h1);
        test_instr(4'h2);
        test_instr(4'h0);
        test_instr(4'hE);
        test_instr(4'h7);
        test_pause();
        test_hlt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
